// File: rtl/l2_data_pkg.sv
// rtl/l2_data_pkg.sv - shared constants and state type for the L2 data-array controller
package l2_data_pkg;

  localparam int unsigned L2_DATA_WIDTH = 1024;
  localparam int unsigned L2_ADDR_WIDTH = 7;
  localparam int unsigned L2_ID_WIDTH   = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/l2_rsp_fifo.sv
// rtl/l2_rsp_fifo.sv - two-entry {id, data} response FIFO with occupancy count
module l2_rsp_fifo #(
  parameter int DATA_WIDTH = 1024,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [ID_WIDTH-1:0]   push_id_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            count_o
);

  logic [ID_WIDTH-1:0]   id_q   [2];
  logic [DATA_WIDTH-1:0] data_q [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  // The credit check upstream keeps push from ever landing on a full FIFO; the guards are belt-and-braces.
  assign push_ok = push_i && (count_q != 2'd2);
  assign pop_ok  = pop_i && (count_q != 2'd0);

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Control state; storage below needs no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written at the write pointer.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      id_q[wr_ptr_q]   <= push_id_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign id_o    = id_q[rd_ptr_q];
  assign data_o  = data_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/l2_data_array_ctrl.sv
// rtl/l2_data_array_ctrl.sv - L2 data-array SRAM initiator: zero-fill, write/read arbitration, read response buffering
module l2_data_array_ctrl
  import l2_data_pkg::*;
#(
  parameter int DATA_WIDTH = L2_DATA_WIDTH,
  parameter int ADDR_WIDTH = L2_ADDR_WIDTH,
  parameter int NUM_WMASKS = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = L2_ID_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic [NUM_WMASKS-1:0] wr_req_mask,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [ID_WIDTH-1:0]   rd_req_id,
  output logic                  rd_rsp_valid,
  input  logic                  rd_rsp_ready,
  output logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic [ID_WIDTH-1:0]   rd_rsp_id,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  inflight_q;
  logic [ID_WIDTH-1:0]   inflight_id_q;

  logic                  in_init;
  logic                  in_run;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  collision;
  logic                  rsp_pop;
  logic                  credit_ok;
  logic [2:0]            occupancy;
  logic                  fifo_valid;
  logic [1:0]            fifo_count;

  // rst masks every outward-facing control in the same cycle it is seen, not only after the edge.
  assign in_init = (state_q == INIT) && !rst;
  assign in_run  = (state_q == RUN) && !rst;

  assign init_done    = in_run;
  assign wr_req_ready = in_run;
  assign wr_fire      = wr_req_valid && wr_req_ready;

  // Same-row write and read in one cycle: let the write land first so the read sees it next cycle.
  assign collision = wr_req_valid && rd_req_valid && (wr_req_addr == rd_req_addr);

  assign rsp_pop = rd_rsp_valid && rd_rsp_ready;

  // Count the read in flight and credit back a same-cycle pop, so the 2-entry FIFO never overflows
  // yet one read per cycle is sustained while responses drain.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, rsp_pop};
  assign credit_ok = (occupancy < 3'd2);

  assign rd_req_ready = in_run && !collision && credit_ok;
  assign rd_fire      = rd_req_valid && rd_req_ready;

  // Write port: zero-fill sweep during INIT, otherwise the accepted write request.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_addr0  = init_cnt_q;
    sram_wmask0 = '0;
    sram_din0   = '0;
    if (in_init) begin
      sram_csb0   = 1'b0;
      sram_addr0  = init_cnt_q;
      sram_wmask0 = '1;
      sram_din0   = '0;
    end else if (wr_fire) begin
      sram_csb0   = 1'b0;
      sram_addr0  = wr_req_addr;
      sram_wmask0 = wr_req_mask;
      sram_din0   = wr_req_data;
    end
  end

  assign sram_csb1  = !rd_fire;
  assign sram_addr1 = rd_req_addr;

  // FSM next-state: walk every row once, then run.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == LAST_ROW) state_d = RUN;
    end
  end

  // FSM, init counter and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT;
      init_cnt_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      inflight_q <= rd_fire;
      if (rd_fire) inflight_id_q <= rd_req_id;
    end
  end

  // dout1 is only trustworthy around the edge after issue, so capture straight into the FIFO there.
  l2_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) u_rsp_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (inflight_q),
    .push_id_i   (inflight_id_q),
    .push_data_i (sram_dout1),
    .pop_i       (rsp_pop),
    .valid_o     (fifo_valid),
    .id_o        (rd_rsp_id),
    .data_o      (rd_rsp_data),
    .count_o     (fifo_count)
  );

  assign rd_rsp_valid = fifo_valid && !rst;

endmodule

// File: tb/tb_l2_data_array_ctrl.sv
// tb/tb_l2_data_array_ctrl.sv - scoreboard bench for l2_data_array_ctrl with a behavioural SRAM macro
module tb_l2_data_array_ctrl;

  localparam int DW    = 1024;
  localparam int AW    = 7;
  localparam int NM    = DW / 8;
  localparam int IW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } sb_entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req_valid, wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [NM-1:0] wr_req_mask;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [IW-1:0] rd_req_id;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic [IW-1:0] rd_rsp_id;
  logic          init_done;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [NM-1:0] sram_wmask0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout1;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  sb_entry_t     sb [$];
  sb_entry_t     mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;

  always #5 clk = ~clk;

  l2_data_array_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .wr_req_mask  (wr_req_mask),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_req_id    (rd_req_id),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .rd_rsp_id    (rd_rsp_id),
    .init_done    (init_done),
    .sram_csb0    (sram_csb0),
    .sram_csb1    (sram_csb1),
    .sram_addr0   (sram_addr0),
    .sram_addr1   (sram_addr1),
    .sram_wmask0  (sram_wmask0),
    .sram_din0    (sram_din0),
    .sram_dout1   (sram_dout1)
  );

  // SRAM macro model; reset scribbles every row so the zero-fill has to really happen.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= {32{32'hDEAD_0000 | r}};
    end else begin
      if (!sram_csb0)
        for (int b = 0; b < NM; b++)
          if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      for (int k = 0; k < DW / 64; k++) begin
        if (got[k*64 +: 64] !== exp[k*64 +: 64]) begin
          $display("FAIL %s word%0d got=%h exp=%h", tag, k, got[k*64 +: 64], exp[k*64 +: 64]);
          break;
        end
      end
    end
  endtask

  // Monitor: check popped responses, queue expectations on read accept, track writes in the reference.
  always @(negedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) ref_mem[r] = '0;
    end else begin
      if (rd_rsp_valid && rd_rsp_ready) begin
        chk("rsp_expected", DW'(sb.size() != 0), DW'(1));
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("rsp_id", DW'(rd_rsp_id), DW'(mon_e.id));
          chk("rsp_data", rd_rsp_data, mon_e.data);
        end
      end
      if (rd_req_valid && rd_req_ready)
        sb.push_back('{id: rd_req_id, data: ref_mem[rd_req_addr]});
      if (wr_req_valid && wr_req_ready)
        for (int b = 0; b < NM; b++)
          if (wr_req_mask[b]) ref_mem[wr_req_addr][b*8 +: 8] = wr_req_data[b*8 +: 8];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_csb0", DW'(sram_csb0), DW'(1));
    chk("rst_csb1", DW'(sram_csb1), DW'(1));
    chk("rst_init_done", DW'(init_done), DW'(0));
    chk("rst_wr_rdy", DW'(wr_req_ready), DW'(0));
    chk("rst_rd_rdy", DW'(rd_req_ready), DW'(0));
    chk("rst_rsp_valid", DW'(rd_rsp_valid), DW'(0));
  endtask

  // Called at the start of cycle 0; checks the sweep, optionally returning at the negedge of cycle stop_at.
  task automatic init_scan(input int stop_at);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("init_csb0", DW'(sram_csb0), DW'(0));
      chk("init_addr0", DW'(sram_addr0), DW'(i));
      chk("init_wmask0", DW'(sram_wmask0), DW'({NM{1'b1}}));
      chk("init_din0", sram_din0, DW'(0));
      chk("init_csb1", DW'(sram_csb1), DW'(1));
      chk("init_done_lo", DW'(init_done), DW'(0));
      chk("init_wr_rdy", DW'(wr_req_ready), DW'(0));
      chk("init_rd_rdy", DW'(rd_req_ready), DW'(0));
      if (i == stop_at) return;
    end
    @(negedge clk);
    chk("init_done_hi", DW'(init_done), DW'(1));
    chk("init_wr_rdy_hi", DW'(wr_req_ready), DW'(1));
  endtask

  // Returns at the start of the cycle after the accept.
  task automatic do_read(input logic [AW-1:0] addr, input logic [IW-1:0] id);
    int n;
    step();
    rd_req_valid = 1'b1;
    rd_req_addr  = addr;
    rd_req_id    = id;
    n = 0;
    @(negedge clk);
    while (!rd_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk("rd_accept", DW'(rd_req_ready), DW'(1));
    step();
    rd_req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [NM-1:0] mask);
    step();
    wr_req_valid = 1'b1;
    wr_req_addr  = addr;
    wr_req_data  = data;
    wr_req_mask  = mask;
    step();
    wr_req_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] wd;
    logic [NM-1:0] wm;
    rst = 1'b1;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0; wr_req_mask = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_id = '0;
    rd_rsp_ready = 1'b1;

    // Reset, then the full zero-fill sweep.
    repeat (3) step();
    @(negedge clk);
    chk_reset_outputs();
    step();
    rst = 1'b0;
    init_scan(-1);

    // Zero-filled row returns zeros with its ID; 2-cycle latency.
    do_read(7'd5, 4'd3);
    @(negedge clk); chk("lat_t1_rsp_valid", DW'(rd_rsp_valid), DW'(0));
    @(negedge clk); chk("lat_t2_rsp_valid", DW'(rd_rsp_valid), DW'(1));
    chk("lat_t2_rsp_id", DW'(rd_rsp_id), DW'(3));

    // Byte-masked write then read back.
    do_write(7'd3, {128{8'hA5}}, NM'(16'h000F));
    do_read(7'd3, 4'd1);
    @(negedge clk); chk("mask_t1_rsp_valid", DW'(rd_rsp_valid), DW'(0));
    @(negedge clk); chk("mask_t2_rsp_valid", DW'(rd_rsp_valid), DW'(1));
    chk("mask_t2_rsp_data", rd_rsp_data, DW'(32'hA5A5_A5A5));

    // Same-row write and read collide: read stalls one cycle and sees the new data.
    step();
    wr_req_valid = 1'b1; wr_req_addr = 7'd9; wr_req_data = '1; wr_req_mask = '1;
    rd_req_valid = 1'b1; rd_req_addr = 7'd9; rd_req_id = 4'd7;
    @(negedge clk);
    chk("coll_rd_rdy_lo", DW'(rd_req_ready), DW'(0));
    chk("coll_wr_rdy", DW'(wr_req_ready), DW'(1));
    step();
    wr_req_valid = 1'b0;
    @(negedge clk);
    chk("coll_rd_rdy_hi", DW'(rd_req_ready), DW'(1));
    step();
    rd_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("coll_rsp_id", DW'(rd_rsp_id), DW'(7));
    chk("coll_rsp_data", rd_rsp_data, '1);

    // Random data/masks into rows 20..29, then 10 back-to-back reads.
    for (int i = 0; i < 10; i++) begin
      for (int w = 0; w < DW / 32; w++) wd[w*32 +: 32] = $urandom;
      for (int w = 0; w < NM / 32; w++) wm[w*32 +: 32] = $urandom;
      do_write(AW'(20 + i), wd, wm);
    end
    step();
    rd_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_req_addr = AW'(20 + i);
      rd_req_id   = IW'(i);
      @(negedge clk);
      chk("b2b_rd_rdy", DW'(rd_req_ready), DW'(1));
      chk("b2b_rsp_valid", DW'(rd_rsp_valid), DW'(i >= 2));
      step();
    end
    rd_req_valid = 1'b0;
    @(negedge clk); chk("b2b_tail0_valid", DW'(rd_rsp_valid), DW'(1));
    @(negedge clk); chk("b2b_tail1_valid", DW'(rd_rsp_valid), DW'(1));
    @(negedge clk); chk("b2b_tail2_valid", DW'(rd_rsp_valid), DW'(0));

    // Back-pressure: two reads fill the credit, the third waits for the first pop.
    step();
    rd_rsp_ready = 1'b0;
    rd_req_valid = 1'b1; rd_req_addr = 7'd20; rd_req_id = 4'd10;
    @(negedge clk); chk("bp_rd0_rdy", DW'(rd_req_ready), DW'(1));
    step();
    rd_req_addr = 7'd21; rd_req_id = 4'd11;
    @(negedge clk); chk("bp_rd1_rdy", DW'(rd_req_ready), DW'(1));
    step();
    rd_req_addr = 7'd22; rd_req_id = 4'd12;
    @(negedge clk); chk("bp_rd2_held", DW'(rd_req_ready), DW'(0));
    step();
    @(negedge clk);
    chk("bp_rd2_held_again", DW'(rd_req_ready), DW'(0));
    chk("bp_head_valid", DW'(rd_rsp_valid), DW'(1));
    chk("bp_head_id", DW'(rd_rsp_id), DW'(10));
    step();
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rd2_on_pop", DW'(rd_req_ready), DW'(1));
    chk("bp_pop_valid", DW'(rd_rsp_valid), DW'(1));
    step();
    rd_req_valid = 1'b0;
    repeat (5) step();
    chk("bp_drained", DW'(sb.size()), DW'(0));

    // Reset in the middle of the sweep at row 60, then a clean restart from row 0.
    step();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    step();
    rst = 1'b0;
    init_scan(60);
    rst = 1'b1;
    #1;
    chk("mid_init_rst_csb0", DW'(sram_csb0), DW'(1));
    step();
    rst = 1'b0;
    init_scan(-1);

    // Reset while a read is in flight: its response must never appear.
    do_read(7'd20, 4'd5);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_reset_outputs();
    step();
    rst = 1'b0;
    init_scan(-1);
    chk("run_rst_fifo_empty", DW'(rd_rsp_valid), DW'(0));

    // After the second fill, row 3 is zero again.
    do_read(7'd3, 4'd14);
    @(negedge clk);
    @(negedge clk);
    chk("refill_rsp_valid", DW'(rd_rsp_valid), DW'(1));
    repeat (3) step();
    chk("final_sb_empty", DW'(sb.size()), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_data_array_ctrl.md
# l2_data_array_ctrl

Single-clock initiator for the dual-port L2 data-array SRAM macro: it drives the macro's write port (port 0) and read port (port 1), and samples the read data. It zero-fills the array after reset and arbitrates read/write collisions at the same address. It also buffers read responses behind a valid/ready handshake with ordered IDs. It sits between the L2 cache controller and the data-array macro; both macro clocks are tied to `clk`.

## Interface
- `DATA_WIDTH`, 1024: line width in bits.
- `ADDR_WIDTH`, 7: row address width; depth = 1 << ADDR_WIDTH.
- `NUM_WMASKS`, DATA_WIDTH/8: byte-enable count.
- `ID_WIDTH`, 4: read tag width.
- `clk`  in  1  sole clock; also drives macro clk0/clk1.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_req_valid` / `wr_req_ready`  in/out  1  write handshake.
- `wr_req_addr`  in  ADDR_WIDTH  write row.
- `wr_req_data`  in  DATA_WIDTH  write data.
- `wr_req_mask`  in  NUM_WMASKS  byte enables; bit i covers data[8i+:8].
- `rd_req_valid` / `rd_req_ready`  in/out  1  read handshake.
- `rd_req_addr`  in  ADDR_WIDTH  read row.
- `rd_req_id`  in  ID_WIDTH  tag, returned with data.
- `rd_rsp_valid` / `rd_rsp_ready`  out/in  1  response handshake.
- `rd_rsp_data`  out  DATA_WIDTH;  `rd_rsp_id`  out  ID_WIDTH.
- `init_done`  out  1  high once zero-fill completes.
- `sram_csb0`, `sram_csb1`  out  1  active-low selects, write/read port.
- `sram_addr0`, `sram_addr1`  out  ADDR_WIDTH.
- `sram_wmask0`  out  NUM_WMASKS;  `sram_din0`  out  DATA_WIDTH.
- `sram_dout1`  in  DATA_WIDTH  macro read data.

## Operation
- FSM states: INIT, RUN. `rst` forces INIT with init counter 0, empties the response FIFO, and clears the in-flight flag. While `rst` is high: `sram_csb0`=`sram_csb1`=1, `init_done`=0, all readies 0, `rd_rsp_valid`=0.
- INIT: each cycle drive `sram_csb0`=0, `sram_addr0`=counter, `sram_wmask0`=all ones, `sram_din0`=0. Increment the counter. After row depth-1 is written, go to RUN. Ports `sram_csb1`=1, `wr_req_ready`=0 and `rd_req_ready`=0 throughout INIT.
- RUN: `init_done`=1. `wr_req_ready`=1, so writes are never back-pressured. An accepted write drives the port-0 signals combinationally from the request in the same cycle; otherwise `sram_csb0`=1.
- Read issue: `rd_req_ready` = RUN AND no collision AND credit.
  - Collision: `wr_req_valid` and `rd_req_valid` both high with `wr_req_addr`==`rd_req_addr`. The write proceeds and the read stalls one cycle.
  - Credit: (FIFO count + in-flight − pop-this-cycle) < 2.
  - An accepted read drives `sram_csb1`=0 and `sram_addr1` combinationally, sets in-flight, and registers its ID.
- Capture: on the posedge after issue, `sram_dout1` and the registered ID are pushed into the 2-entry response FIFO. `sram_dout1` is sampled only on this posedge, because the macro drives X shortly after each clk1 edge.
- Response: `rd_rsp_*` present the FIFO head. Pop when `rd_rsp_valid` and `rd_rsp_ready` are both high. Responses return in issue order.
- Reset mid-operation (INIT or RUN): discard in-flight reads and FIFO contents, then restart INIT from row 0.

## Timing
- Read accepted in cycle T: data is captured at the end of T+1, and `rd_rsp_valid` is high from T+2. Minimum latency is 2 cycles.
- With `rd_rsp_ready` held high, sustained throughput is 1 read per cycle.
- Write accepted in cycle T: visible to any read accepted in T+1 or later. A same-address read presented in T is stalled into T+1 and returns the new data.
- Byte-masked write: unmasked bytes keep their previous value.
- With `rst` deasserted at the edge starting cycle 0: INIT occupies cycles 0..depth-1, and `init_done` rises in cycle depth (128 at the default depth).

## Structure
- Package `l2_data_pkg`: default width/depth constants, and the `state_t` enum {INIT, RUN}.
- Sub-module `l2_rsp_fifo`: 2-entry FIFO of {id, data} with count output, push/pop, and synchronous reset.
- Top level: FSM, init counter, collision/credit logic, port muxing.

## Test plan
- Reset release: 128 consecutive cycles with `sram_csb0`=0, addr 0..127, mask all ones, din 0. `init_done`=1 at cycle 128. Read row 5 returns all-zero data with the ID intact.
- Write row 3 with data 0xA5 per byte and mask 0x…000F, then read row 3 → bytes 0–3 = 0xA5, all other bytes 0. Response arrives 2 cycles after read accept.
- Same-cycle write row 9 = 0xFF…, read row 9 with ID 7 → `rd_req_ready`=0 for that cycle. The read is issued the next cycle and returns 0xFF… with ID 7.
- 10 back-to-back reads (IDs 0..9), `rd_rsp_ready`=1 → 10 consecutive valid responses, IDs 0..9 in order, first at accept+2.
- `rd_rsp_ready`=0 with 3 reads offered → two accepted, third held (`rd_req_ready`=0). Raising `rd_rsp_ready` drains them in order, and the third is accepted the same cycle as the first pop.
- Assert `rst` when the init counter reaches 60, and while a read is in flight in RUN → FIFO empty, INIT restarts at row 0, `init_done` low until 128 cycles after release.
